// File: rtl/bcd_seq_display_driver.sv
// -----------------------------------------------------------------------------
// bcd_seq_display_driver
//
// Converts a binary value to packed BCD with an iterative double-dabble engine
// (one add-3/shift step per clock), then drives DIGITS active-low 7-segment
// displays from the result. Supports optional two's-complement input (the
// leftmost digit then carries the minus sign) and leading-zero blanking.
//
// Ports
//   clk       in   1            system clock, rising edge
//   rst       in   1            synchronous reset, active-high
//   start     in   1            request conversion of bin_in (taken only when idle)
//   bin_in    in   WIDTH        value to convert
//   busy      out  1            conversion in progress
//   done      out  1            one-cycle pulse: bcd_out/segments just updated
//   bcd_out   out  4*DIGITS     packed BCD of |value|, nibble [3:0] = units
//   negative  out  1            sign of last converted value (0 when !SIGNED)
//   segments  out  [0:7*DIGITS-1] big-endian; [0:6] = leftmost digit {a..g}
// -----------------------------------------------------------------------------
module bcd_seq_display_driver #(
  parameter int WIDTH         = 8,
  parameter int DIGITS        = 3,
  parameter int SIGNED        = 0,
  parameter int LEADING_BLANK = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WIDTH-1:0]        bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [4*DIGITS-1:0]     bcd_out,
  output logic                    negative,
  output logic [0:7*DIGITS-1]     segments
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;

  function automatic longint f_pow(input int base, input int expo);
    longint r;
    r = 1;
    for (int k = 0; k < expo; k++) r = r * base;
    return r;
  endfunction

  // The BCD scratch must be able to hold the largest magnitude; in signed
  // mode the leftmost digit is kept free for the sign.
  generate
    if (SIGNED == 0) begin : g_chk_unsigned
      if (!(f_pow(10, DIGITS) > f_pow(2, WIDTH) - 1)) begin : g_err
        $error("bcd_seq_display_driver: DIGITS too small for unsigned WIDTH");
      end
    end else begin : g_chk_signed
      if (!(f_pow(10, DIGITS - 1) > f_pow(2, WIDTH - 1))) begin : g_err
        $error("bcd_seq_display_driver: DIGITS too small for signed WIDTH");
      end
    end
  endgenerate

  // {a,b,c,d,e,f,g}, active-low
  function automatic logic [6:0] f_seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Digit i occupies bits [7*i +: 7]; the leftmost digit sits in the top bits
  // so that it lands on segments[0:6] of the big-endian port.
  function automatic logic [7*DIGITS-1:0] f_display(input logic [4*DIGITS-1:0] bcd,
                                                    input logic                neg);
    logic [7*DIGITS-1:0] seg;
    logic                lead_zero;
    logic [3:0]          nib;
    seg       = '0;
    lead_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib       = bcd[4*i +: 4];
      lead_zero = lead_zero & (nib == 4'd0);
      if (SIGNED != 0 && i == DIGITS - 1 && neg)
        seg[7*i +: 7] = SEG_MINUS;
      else if (LEADING_BLANK != 0 && lead_zero && i != 0)
        seg[7*i +: 7] = SEG_BLANK;
      else
        seg[7*i +: 7] = f_seg7(nib);
    end
    return seg;
  endfunction

  typedef enum logic {S_IDLE, S_CONVERT} state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [WIDTH-1:0]      r_bin;
  logic [4*DIGITS-1:0]   r_bcd;
  logic                  r_sign;
  logic                  r_busy;
  logic                  r_done;
  logic [4*DIGITS-1:0]   r_bcd_out;
  logic                  r_neg;
  logic [7*DIGITS-1:0]   r_seg;

  logic                  w_sign;
  logic [WIDTH-1:0]      w_mag;
  logic [4*DIGITS-1:0]   w_bcd_adj;
  logic [4*DIGITS-1:0]   w_bcd_next;

  // Magnitude capture: negating the most negative value wraps to itself,
  // which read as unsigned is exactly its magnitude.
  always_comb begin
    w_sign = (SIGNED != 0) && bin_in[WIDTH-1];
    w_mag  = w_sign ? (-bin_in) : bin_in;
  end

  // One double-dabble step: add 3 to nibbles >= 5, then shift the next
  // binary bit into the BCD LSB.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_bcd_next = {w_bcd_adj[4*DIGITS-2:0], r_bin[WIDTH-1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bcd_out <= '0;
      r_neg     <= 1'b0;
      r_seg     <= f_display('0, 1'b0);
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bin   <= w_mag;
            r_sign  <= w_sign;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          r_bcd <= w_bcd_next;
          r_bin <= {r_bin[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
          // Last step: publish the result straight from the step logic.
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_bcd_out <= w_bcd_next;
            r_neg     <= r_sign;
            r_seg     <= f_display(w_bcd_next, r_sign);
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign bcd_out  = r_bcd_out;
  assign negative = r_neg;
  assign segments = r_seg;

endmodule

// File: tb/tb_bcd_seq_display_driver.sv
module tb_bcd_seq_display_driver;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [7:0] bin_in;

  logic        busy_u, done_u, neg_u;
  logic [11:0] bcd_u;
  logic [20:0] seg_u;
  logic        busy_n, done_n, neg_n;
  logic [11:0] bcd_n;
  logic [20:0] seg_n;
  logic        busy_s, done_s, neg_s;
  logic [15:0] bcd_s;
  logic [27:0] seg_s;

  always #5 clk = ~clk;

  bcd_seq_display_driver #(.WIDTH(8), .DIGITS(3), .SIGNED(0), .LEADING_BLANK(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in), .busy(busy_u), .done(done_u),
    .bcd_out(bcd_u), .negative(neg_u), .segments(seg_u));

  bcd_seq_display_driver #(.WIDTH(8), .DIGITS(3), .SIGNED(0), .LEADING_BLANK(0)) u_nb (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in), .busy(busy_n), .done(done_n),
    .bcd_out(bcd_n), .negative(neg_n), .segments(seg_n));

  bcd_seq_display_driver #(.WIDTH(8), .DIGITS(4), .SIGNED(1), .LEADING_BLANK(1)) u_sg (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in), .busy(busy_s), .done(done_s),
    .bcd_out(bcd_s), .negative(neg_s), .segments(seg_s));

  localparam logic [6:0] D0 = 7'b0000001, D1 = 7'b1001111, D2 = 7'b0010010,
                         D3 = 7'b0000110, D4 = 7'b1001100, D5 = 7'b0100100,
                         D6 = 7'b0100000, D7 = 7'b0001111, D8 = 7'b0000000,
                         D9 = 7'b0000100, DB = 7'b1111111, DM = 7'b1111110;
  localparam logic [6:0] SEG_TAB [0:9] = '{D0, D1, D2, D3, D4, D5, D6, D7, D8, D9};

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] last_bcd_u;
  logic [15:0] last_bcd_s;

  typedef struct {
    logic [7:0]  v;
    logic [11:0] bcd_u;
    logic [20:0] seg_u;
    logic [20:0] seg_n;
    logic [15:0] bcd_s;
    logic        neg_s;
    logic [27:0] seg_s;
  } vec_t;

  vec_t tab [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: plain decimal arithmetic on the magnitude.
  function automatic int m_mag(input logic [7:0] v, input bit sgn);
    if (sgn && v[7]) return 256 - int'(v);
    return int'(v);
  endfunction

  function automatic logic [31:0] m_bcd(input logic [7:0] v, input bit sgn);
    int mag;
    logic [31:0] r;
    mag = m_mag(v, sgn);
    r = '0;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] m_seg(input logic [7:0] v, input int digits,
                                        input bit sgn, input bit lb);
    int mag, t, ndig;
    int dig [4];
    logic [6:0] code;
    logic [31:0] r;
    mag = m_mag(v, sgn);
    ndig = 1;
    t = mag / 10;
    while (t > 0) begin
      ndig++;
      t = t / 10;
    end
    t = mag;
    for (int d = 0; d < 4; d++) begin
      dig[d] = t % 10;
      t = t / 10;
    end
    r = '0;
    for (int pos = digits - 1; pos >= 0; pos--) begin
      code = SEG_TAB[dig[pos]];
      if (lb && pos >= ndig) code = DB;
      if (sgn && pos == digits - 1) code = (v[7]) ? DM : (lb ? DB : D0);
      r = (r << 7) | 32'(code);
    end
    return r;
  endfunction

  // Called at the negedge after the accepting edge; keeps start/bin_in
  // toggling while the conversion runs.
  task automatic wait_done(output int lat, output int bcyc);
    bit held;
    lat  = 0;
    bcyc = 0;
    held = 1'b1;
    while (!done_u && lat < 20) begin
      if (busy_u) bcyc++;
      if (bcd_u !== last_bcd_u || bcd_s !== last_bcd_s || done_n || done_s) held = 1'b0;
      start  = 1'($urandom);
      bin_in = 8'($urandom);
      tick;
      lat++;
    end
    start = 1'b0;
    chk("hold_during_convert", 32'(held), 32'd1);
  endtask

  task automatic conv(input logic [7:0] v, output int lat, output int bcyc);
    start  = 1'b1;
    bin_in = v;
    tick;
    wait_done(lat, bcyc);
  endtask

  task automatic check_out(input string tag, input logic [31:0] eb_u, input logic [31:0] es_u,
                           input logic [31:0] es_n, input logic [31:0] eb_s,
                           input logic [31:0] en_s, input logic [31:0] es_s);
    chk({tag, "_done_u"}, 32'(done_u), 32'd1);
    chk({tag, "_done_n"}, 32'(done_n), 32'd1);
    chk({tag, "_done_s"}, 32'(done_s), 32'd1);
    chk({tag, "_busy"},   32'({busy_u, busy_n, busy_s}), 32'd0);
    chk({tag, "_bcd_u"},  32'(bcd_u), eb_u);
    chk({tag, "_seg_u"},  32'(seg_u), es_u);
    chk({tag, "_bcd_n"},  32'(bcd_n), eb_u);
    chk({tag, "_seg_n"},  32'(seg_n), es_n);
    chk({tag, "_neg_un"}, 32'({neg_u, neg_n}), 32'd0);
    chk({tag, "_bcd_s"},  32'(bcd_s), eb_s);
    chk({tag, "_neg_s"},  32'(neg_s), en_s);
    chk({tag, "_seg_s"},  32'(seg_s), es_s);
    last_bcd_u = eb_u[11:0];
    last_bcd_s = eb_s[15:0];
  endtask

  task automatic check_model(input string tag, input logic [7:0] v);
    check_out(tag, m_bcd(v, 1'b0), m_seg(v, 3, 1'b0, 1'b1), m_seg(v, 3, 1'b0, 1'b0),
              m_bcd(v, 1'b1), 32'(v[7]), m_seg(v, 4, 1'b1, 1'b1));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, 32'({busy_u, busy_n, busy_s}), 32'd0);
    chk({tag, "_done"}, 32'({done_u, done_n, done_s}), 32'd0);
    chk({tag, "_bcd"},  32'({bcd_u, bcd_n}), 32'd0);
    chk({tag, "_bcd_s"}, 32'(bcd_s), 32'd0);
    chk({tag, "_neg"},  32'({neg_u, neg_n, neg_s}), 32'd0);
    chk({tag, "_seg_u"}, 32'(seg_u), 32'({DB, DB, D0}));
    chk({tag, "_seg_n"}, 32'(seg_n), 32'({D0, D0, D0}));
    chk({tag, "_seg_s"}, 32'(seg_s), 32'({DB, DB, DB, D0}));
    last_bcd_u = '0;
    last_bcd_s = '0;
  endtask

  initial begin
    int lat, bcyc;
    bit saw_done;
    logic [7:0] v;

    tab[0] = '{8'd255,  12'h255, {D2, D5, D5}, {D2, D5, D5}, 16'h0001, 1'b1, {DM, DB, DB, D1}};
    tab[1] = '{8'd7,    12'h007, {DB, DB, D7}, {D0, D0, D7}, 16'h0007, 1'b0, {DB, DB, DB, D7}};
    tab[2] = '{8'h80,   12'h128, {D1, D2, D8}, {D1, D2, D8}, 16'h0128, 1'b1, {DM, D1, D2, D8}};
    tab[3] = '{8'hFB,   12'h251, {D2, D5, D1}, {D2, D5, D1}, 16'h0005, 1'b1, {DM, DB, DB, D5}};
    tab[4] = '{8'd42,   12'h042, {DB, D4, D2}, {D0, D4, D2}, 16'h0042, 1'b0, {DB, DB, D4, D2}};
    tab[5] = '{8'd0,    12'h000, {DB, DB, D0}, {D0, D0, D0}, 16'h0000, 1'b0, {DB, DB, DB, D0}};
    tab[6] = '{8'd100,  12'h100, {D1, D0, D0}, {D1, D0, D0}, 16'h0100, 1'b0, {DB, D1, D0, D0}};
    tab[7] = '{8'd127,  12'h127, {D1, D2, D7}, {D1, D2, D7}, 16'h0127, 1'b0, {DB, D1, D2, D7}};

    rst = 1'b1; start = 1'b0; bin_in = '0;
    last_bcd_u = '0; last_bcd_s = '0;
    @(negedge clk);
    tick;
    tick;
    rst = 1'b0;
    tick;
    check_reset("reset");

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      conv(tab[i].v, lat, bcyc);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
      chk($sformatf("vec%0d_busy_cycles", i), 32'(bcyc), 32'd8);
      check_out($sformatf("vec%0d", i), 32'(tab[i].bcd_u), 32'(tab[i].seg_u), 32'(tab[i].seg_n),
                32'(tab[i].bcd_s), 32'(tab[i].neg_s), 32'(tab[i].seg_s));
      tick;
      chk($sformatf("vec%0d_done_pulse", i), 32'({done_u, done_n, done_s}), 32'd0);
      chk($sformatf("vec%0d_result_held", i), 32'(bcd_u), 32'(tab[i].bcd_u));
    end

    // Back-to-back: second start issued in the done cycle
    conv(8'd200, lat, bcyc);
    chk("b2b_first_latency", 32'(lat), 32'd8);
    check_out("b2b_first", 32'h200, 32'({D2, D0, D0}), 32'({D2, D0, D0}),
              32'h0056, 32'd1, 32'({DM, DB, D5, D6}));
    conv(8'd42, lat, bcyc);
    chk("b2b_second_latency", 32'(lat), 32'd8);
    check_out("b2b_second", 32'h042, 32'({DB, D4, D2}), 32'({D0, D4, D2}),
              32'h0042, 32'd0, 32'({DB, DB, D4, D2}));
    tick;

    // Reset in the middle of a conversion
    start = 1'b1; bin_in = 8'd99;
    tick;
    start = 1'b0;
    tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_reset("midrst");
    saw_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (done_u || done_n || done_s || busy_u) saw_done = 1'b1;
      tick;
    end
    chk("midrst_no_done", 32'(saw_done), 32'd0);
    conv(8'd153, lat, bcyc);
    chk("midrst_fresh_latency", 32'(lat), 32'd8);
    check_model("midrst_fresh", 8'd153);

    // Randomized conversions against the model
    for (int r = 0; r < 40; r++) begin
      v = 8'($urandom);
      if (r % 8 == 0) v = (r % 16 == 0) ? 8'h80 : 8'h7F;
      conv(v, lat, bcyc);
      chk($sformatf("rand%0d_latency", r), 32'(lat), 32'd8);
      check_model($sformatf("rand%0d_v%0h", r, v), v);
      if ($urandom_range(0, 1) == 1) begin
        for (int g = $urandom_range(1, 3); g > 0; g--) tick;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
